// File: rtl/row_insert.sv
// Garbage-row inserter for the Tetris playfield.
// Pushes clamped count rows in at the bottom, one per clock.
module row_insert #(
  parameter int         WIDTH     = 20,
  parameter int         HEIGHT    = 20,
  parameter int         MAX_ROWS  = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2:0]                count,
  input  logic [WIDTH*HEIGHT-1:0]   matrix_in,
  output logic [WIDTH*HEIGHT-1:0]   matrix_out,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);

  localparam int         N    = WIDTH * HEIGHT;
  localparam logic [2:0] MAXR = 3'(MAX_ROWS);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q;
  logic [7:0]        lfsr_q;
  logic [2:0]        rem_q;

  logic [2:0]        cnt_d;
  logic [7:0]        lfsr_d;
  logic [31:0]       hole_d;
  logic [WIDTH-1:0]  row_d;
  logic [N-1:0]      shift_d;
  logic              top_nz_d;

  // Request clamp, hole position and shifted field
  always_comb begin
    cnt_d    = (count > MAXR) ? MAXR : count;
    lfsr_d   = {lfsr_q[6:0],
                lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    hole_d   = {27'd0, lfsr_q[4:0]} % 32'(WIDTH);
    row_d    = ~({{(WIDTH-1){1'b0}}, 1'b1} << hole_d);
    shift_d  = {row_d, matrix_out[N-1:WIDTH]};
    top_nz_d = |matrix_out[WIDTH-1:0];
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      matrix_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      rem_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            matrix_out <= matrix_in;
            rem_q      <= cnt_d;
            overflow   <= 1'b0;
            busy       <= 1'b1;
            if (cnt_d != 3'd0) begin
              state_q <= SHIFT;
            end else begin
              state_q <= DONE;
              done    <= 1'b1;
            end
          end
        end
        SHIFT: begin
          matrix_out <= shift_d;
          lfsr_q     <= lfsr_d;
          rem_q      <= rem_q - 3'd1;
          if (top_nz_d) begin
            overflow <= 1'b1;
          end
          if (rem_q == 3'd1) begin
            state_q <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_insert.sv
// Scoreboard bench for row_insert.
// Random requests checked against a row-array model.
module tb_row_insert;

  localparam int W = 20;
  localparam int H = 20;
  localparam int N = W * H;

  logic         clk = 0;
  logic         reset = 1;
  logic         start = 0;
  logic [2:0]   count = 0;
  logic [N-1:0] matrix_in = '0;
  logic [N-1:0] matrix_out;
  logic         busy;
  logic         done;
  logic         overflow;

  row_insert dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .count(count),
    .matrix_in(matrix_in),
    .matrix_out(matrix_out),
    .busy(busy),
    .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] mat;
    bit           ov;
    int           blen;
  } exp_t;

  exp_t         sb[$];
  int           npass = 0;
  int           ntot  = 0;
  bit [7:0]     mlfsr = 8'hA5;
  logic [N-1:0] last_mat;
  bit           last_ov;
  int           bcnt = 0;

  task automatic chk(input string nm, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s act=%h exp=%h", nm, act, exp);
  endtask

  // Reference: field as an array of rows, pushed up one by one
  task automatic model(input logic [N-1:0] m, input int c,
                       output logic [N-1:0] r, output bit ov);
    bit [W-1:0] rows[H];
    int n, hole;
    for (int y = 0; y < H; y++) rows[y] = m[y*W +: W];
    n  = (c > 4) ? 4 : c;
    ov = 0;
    for (int k = 0; k < n; k++) begin
      if (rows[0] != 0) ov = 1;
      for (int y = 0; y < H - 1; y++) rows[y] = rows[y+1];
      hole = (mlfsr % 32) % W;
      rows[H-1] = '1;
      rows[H-1][hole] = 1'b0;
      mlfsr = {mlfsr[6:0],
               mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
    end
    for (int y = 0; y < H; y++) r[y*W +: W] = rows[y];
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy === 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic req(input logic [2:0] c, input logic [N-1:0] m);
    exp_t e;
    int n;
    wait_idle();
    #1;
    start     = 1;
    count     = c;
    matrix_in = m;
    model(m, int'(c), e.mat, e.ov);
    n      = (c > 4) ? 4 : int'(c);
    e.blen = n + 1;
    sb.push_back(e);
    last_mat = e.mat;
    last_ov  = e.ov;
    @(negedge clk);
    start = 0;
  endtask

  function automatic logic [N-1:0] rnd_mat();
    logic [N-1:0] m;
    for (int i = 0; i < N; i += 32) m[i +: 16] = 16'($urandom);
    for (int i = 16; i < N; i += 32) m[i +: 16] = 16'($urandom);
    if ($urandom_range(0, 1) == 0) m[W-1:0] = '0;
    return m;
  endfunction

  // Monitor: compare on each done pulse
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        chk("done_with_busy", busy, 1);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("matrix", matrix_out, e.mat);
          chk("overflow", overflow, e.ov);
          chk("busy_len", bcnt, e.blen);
        end
        bcnt = 0;
      end
    end
  end

  initial begin
    logic [N-1:0] m;
    int t;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_matrix", matrix_out, '0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    reset = 0;

    req(3'd1, '0);
    wait_idle();
    chk("t1_bottom", matrix_out[N-1 -: W], 20'hFFFDF);

    req(3'd1, last_mat);
    wait_idle();
    chk("t2_bottom", matrix_out[N-1 -: W], 20'hFFBFF);
    chk("t2_row18", matrix_out[18*W +: W], 20'hFFFDF);

    req(3'd7, rnd_mat());

    m = rnd_mat();
    m[W-1:0] = '0;
    m[3] = 1'b1;
    req(3'd1, m);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("ovf_sticky", overflow, 1);
    req(3'd0, rnd_mat());
    chk("ovf_clear", overflow, 0);
    wait_idle();
    chk("cnt0_same", matrix_out, matrix_in);

    req(3'd4, rnd_mat());
    #1;
    start     = 1;
    count     = 3'd1;
    matrix_in = '1;
    @(negedge clk);
    start = 0;

    for (int i = 0; i < 20; i++)
      req(3'($urandom_range(0, 7)), rnd_mat());

    req(3'd4, rnd_mat());
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    chk("mid_rst_matrix", matrix_out, '0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", overflow, 0);
    sb.delete();
    mlfsr = 8'hA5;
    @(negedge clk);
    #2;
    reset = 0;
    req(3'd1, '0);
    wait_idle();
    chk("reseed_bottom", matrix_out[N-1 -: W], 20'hFFFDF);

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", 1, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
